// File: rtl/label_argmax_if.sv
// Handshake and data bundle between the upstream score FIFO, label_argmax and the result consumer.
// slave is the argmax block's view; master is the view of whatever drives it.
interface label_argmax_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IDX_WIDTH  = 10
);
    logic                  i_start;
    logic                  i_empty;
    logic                  o_pop;
    logic [DATA_WIDTH-1:0] i_front;
    logic                  i_vld;
    logic [IDX_WIDTH-1:0]  o_idx;
    logic [DATA_WIDTH-1:0] o_max;
    logic                  o_res_vld;
    logic                  i_res_rdy;
    logic                  o_busy;

    modport slave (
        input  i_start, i_empty, i_front, i_vld, i_res_rdy,
        output o_pop, o_idx, o_max, o_res_vld, o_busy
    );

    modport master (
        output i_start, i_empty, i_front, i_vld, i_res_rdy,
        input  o_pop, o_idx, o_max, o_res_vld, o_busy
    );
endinterface

// File: rtl/label_argmax.sv
// Streams NUM_LABELS scores from a FIFO and reports the index and value of the largest one.
// Define LABEL_ARGMAX_SIGNED_EN to compare scores as two's-complement instead of unsigned.
module label_argmax #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_LABELS = 1000,
    parameter int unsigned IDX_WIDTH  = 10
) (
    input logic           clk,
    input logic           rst,
    label_argmax_if.slave bus
);

    localparam int unsigned     CntW      = IDX_WIDTH + 1;
    localparam logic [CntW-1:0] NumLabels = CntW'(NUM_LABELS);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       issue_cnt_q, issue_cnt_d;
    logic [CntW-1:0]       recv_cnt_q, recv_cnt_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  pop;
    logic                  take;
    logic                  clear;
    logic                  greater;

`ifdef LABEL_ARGMAX_SIGNED_EN
    assign greater = $signed(bus.i_front) > $signed(max_q);
`else
    assign greater = bus.i_front > max_q;
`endif

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        max_d       = max_q;
        idx_d       = idx_q;
        pop         = 1'b0;
        clear       = 1'b0;

        // Data may lag pops by any latency, so scores are accepted in both FETCH and DRAIN.
        take = ((state_q == StFetch) || (state_q == StDrain)) && bus.i_vld &&
               (recv_cnt_q < NumLabels);
        if (take) begin
            recv_cnt_d = recv_cnt_q + 1'b1;
            if ((recv_cnt_q == '0) || greater) begin
                max_d = bus.i_front;
                idx_d = recv_cnt_q[IDX_WIDTH-1:0];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    state_d = StFetch;
                    clear   = 1'b1;
                end
            end
            StFetch: begin
                pop = !bus.i_empty && (issue_cnt_q < NumLabels);
                if (pop) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (issue_cnt_d == NumLabels) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (recv_cnt_q == NumLabels) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.i_res_rdy) begin
                    if (bus.i_start) begin
                        state_d = StFetch;
                        clear   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            max_d       = '0;
            idx_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            max_q       <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
        end
    end

    assign bus.o_pop     = pop;
    assign bus.o_busy    = (state_q == StFetch) || (state_q == StDrain);
    assign bus.o_res_vld = (state_q == StDone);
    assign bus.o_idx     = idx_q;
    assign bus.o_max     = max_q;

endmodule

// File: tb/tb_label_argmax.sv
// Bench for label_argmax: a FIFO model with configurable read latency and stalls feeds the
// block, expected results are queued per pass and compared when o_res_vld rises.
module tb_label_argmax;

    localparam int unsigned DW = 16;
    localparam int unsigned NL = 4;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] mx;
    } exp_t;

    typedef struct packed {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    logic clk = 1'b0;
    logic rst;

    label_argmax_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

    label_argmax #(
        .DATA_WIDTH(DW),
        .NUM_LABELS(NL),
        .IDX_WIDTH (IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];
    pend_t         pend_q[$];
    exp_t          exp_q[$];

    int cyc          = 0;
    int lat          = 4;
    int pop_cnt      = 0;
    int vld_cnt      = 0;
    int stall_at     = -1;
    int stall_len    = 0;
    int stall_rem    = 0;
    int stall_cycles = 0;
    int stall_bad    = 0;
    bit flush_req    = 1'b0;

    always #5 clk = ~clk;

    // Pops are taken at the edge; the popped word shows up on i_front lat edges later.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.i_empty === 1'b1 && bus.o_pop !== 1'b0) stall_bad++;
        if (bus.o_pop === 1'b1 && fifo_q.size() > 0) begin
            pend_q.push_back('{due: cyc + lat, data: fifo_q.pop_front()});
            pop_cnt++;
            if (stall_at >= 0 && pop_cnt == stall_at) stall_rem = stall_len;
        end
        if (bus.i_vld === 1'b1) vld_cnt++;
    end

    always @(negedge clk) begin
        if (flush_req) begin
            fifo_q.delete();
            pend_q.delete();
            flush_req = 1'b0;
        end
        bus.i_vld   = 1'b0;
        bus.i_front = '0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc + 1) begin
            bus.i_vld   = 1'b1;
            bus.i_front = pend_q[0].data;
            pend_q.delete(0);
        end
        if (stall_rem > 0) begin
            bus.i_empty = 1'b1;
            stall_rem--;
            stall_cycles++;
        end else begin
            bus.i_empty = (fifo_q.size() == 0);
        end
    end

    function automatic bit greater(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef LABEL_ARGMAX_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    task automatic load_pass(input logic [DW-1:0] a, b, c, d);
        logic [DW-1:0] s[4];
        exp_t e;
        s = '{a, b, c, d};
        e.idx = '0;
        e.mx  = s[0];
        for (int i = 1; i < 4; i++) begin
            if (greater(s[i], e.mx)) begin
                e.idx = IW'(i);
                e.mx  = s[i];
            end
        end
        for (int i = 0; i < 4; i++) fifo_q.push_back(s[i]);
        exp_q.push_back(e);
    endtask

    task automatic start_pass(input logic [DW-1:0] a, b, c, d);
        load_pass(a, b, c, d);
        pop_cnt = 0;
        vld_cnt = 0;
        @(negedge clk) bus.i_start = 1'b1;
        @(negedge clk) bus.i_start = 1'b0;
    endtask

    task automatic wait_res(output bit got);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #2;
            if (bus.o_res_vld === 1'b1) got = 1'b1;
        end
    endtask

    task automatic ack();
        @(negedge clk) bus.i_res_rdy = 1'b1;
        @(negedge clk) bus.i_res_rdy = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        checks++; if (bus.o_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", bus.o_pop); end
        checks++; if (bus.o_res_vld !== 1'b0) begin errors++; $display("FAIL reset_res_vld: got %b want 0", bus.o_res_vld); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        checks++; if (bus.o_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.o_idx); end
        checks++; if (bus.o_max !== '0) begin errors++; $display("FAIL reset_max: got %h want 0", bus.o_max); end
    endtask

    task automatic test_basic();
        bit got;
        exp_t e = 'x;
        start_pass(16'd5, 16'd9, 16'd3, 16'd7);
        wait_res(got);
        checks++; if (!got) begin errors++; $display("FAIL basic_res_vld: not seen within 200 cycles, want 1"); end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++; if (bus.o_idx !== e.idx) begin errors++; $display("FAIL basic_idx: got %0d want %0d", bus.o_idx, e.idx); end
        checks++; if (bus.o_max !== e.mx) begin errors++; $display("FAIL basic_max: got %0d want %0d", bus.o_max, e.mx); end
        checks++; if (bus.o_idx !== 2'd1 || bus.o_max !== 16'd9) begin errors++; $display("FAIL basic_const: got %0d/%0d want 1/9", bus.o_idx, bus.o_max); end
        checks++; if (pop_cnt != 4) begin errors++; $display("FAIL basic_pops: got %0d want 4", pop_cnt); end
        checks++; if (vld_cnt != 4) begin errors++; $display("FAIL basic_vlds: got %0d want 4", vld_cnt); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b want 0", bus.o_busy); end
        ack();
    endtask

    task automatic test_ties();
        bit got;
        exp_t e = 'x;
        start_pass(16'd8, 16'd8, 16'd2, 16'd8);
        wait_res(got);
        checks++; if (!got) begin errors++; $display("FAIL ties_res_vld: not seen within 200 cycles, want 1"); end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++; if (bus.o_idx !== e.idx || bus.o_idx !== 2'd0) begin errors++; $display("FAIL ties_idx: got %0d want 0", bus.o_idx); end
        checks++; if (bus.o_max !== e.mx || bus.o_max !== 16'd8) begin errors++; $display("FAIL ties_max: got %0d want 8", bus.o_max); end
        ack();
        checks++; if (bus.o_res_vld !== 1'b0) begin errors++; $display("FAIL ties_after_ack: res_vld got %b want 0", bus.o_res_vld); end
    endtask

    task automatic test_signedness();
        bit got;
        exp_t e = 'x;
        logic [IW-1:0] want_idx;
        logic [DW-1:0] want_max;
`ifdef LABEL_ARGMAX_SIGNED_EN
        want_idx = 2'd2;
        want_max = 16'h0002;
`else
        want_idx = 2'd1;
        want_max = 16'hFFFF;
`endif
        start_pass(16'h0001, 16'hFFFF, 16'h0002, 16'h0000);
        wait_res(got);
        checks++; if (!got) begin errors++; $display("FAIL sign_res_vld: not seen within 200 cycles, want 1"); end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++; if (bus.o_idx !== e.idx) begin errors++; $display("FAIL sign_idx_sb: got %0d want %0d", bus.o_idx, e.idx); end
        checks++; if (bus.o_max !== e.mx) begin errors++; $display("FAIL sign_max_sb: got %h want %h", bus.o_max, e.mx); end
        checks++; if (bus.o_idx !== want_idx) begin errors++; $display("FAIL sign_idx: got %0d want %0d", bus.o_idx, want_idx); end
        checks++; if (bus.o_max !== want_max) begin errors++; $display("FAIL sign_max: got %h want %h", bus.o_max, want_max); end
        ack();
    endtask

    task automatic test_stall();
        bit got;
        exp_t e = 'x;
        stall_at     = 2;
        stall_len    = 10;
        stall_cycles = 0;
        stall_bad    = 0;
        start_pass(16'd5, 16'd9, 16'd3, 16'd7);
        wait_res(got);
        checks++; if (!got) begin errors++; $display("FAIL stall_res_vld: not seen within 200 cycles, want 1"); end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++; if (bus.o_idx !== e.idx || bus.o_idx !== 2'd1) begin errors++; $display("FAIL stall_idx: got %0d want 1", bus.o_idx); end
        checks++; if (bus.o_max !== e.mx || bus.o_max !== 16'd9) begin errors++; $display("FAIL stall_max: got %0d want 9", bus.o_max); end
        checks++; if (stall_cycles != 10) begin errors++; $display("FAIL stall_len: got %0d want 10", stall_cycles); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_pop: pops while empty %0d want 0", stall_bad); end
        checks++; if (pop_cnt != 4) begin errors++; $display("FAIL stall_pops: got %0d want 4", pop_cnt); end
        stall_at = -1;
        ack();
    endtask

    task automatic test_back_to_back();
        bit got;
        exp_t e = 'x;
        start_pass(16'd5, 16'd9, 16'd3, 16'd7);
        wait_res(got);
        checks++; if (!got) begin errors++; $display("FAIL b2b_res_vld1: not seen within 200 cycles, want 1"); end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++; if (bus.o_idx !== e.idx || bus.o_max !== e.mx) begin errors++; $display("FAIL b2b_res1: got %0d/%0d want %0d/%0d", bus.o_idx, bus.o_max, e.idx, e.mx); end
        load_pass(16'd1, 16'd2, 16'd3, 16'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            checks++; if (bus.o_res_vld !== 1'b1) begin errors++; $display("FAIL b2b_hold_vld: cycle %0d got %b want 1", i, bus.o_res_vld); end
            checks++; if (bus.o_idx !== 2'd1) begin errors++; $display("FAIL b2b_hold_idx: cycle %0d got %0d want 1", i, bus.o_idx); end
            checks++; if (bus.o_max !== 16'd9) begin errors++; $display("FAIL b2b_hold_max: cycle %0d got %0d want 9", i, bus.o_max); end
        end
        @(negedge clk);
        bus.i_res_rdy = 1'b1;
        bus.i_start   = 1'b1;
        pop_cnt       = 0;
        vld_cnt       = 0;
        @(posedge clk);
        #2;
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL b2b_fetch: busy got %b want 1", bus.o_busy); end
        checks++; if (bus.o_pop !== 1'b1) begin errors++; $display("FAIL b2b_pop: got %b want 1", bus.o_pop); end
        @(negedge clk);
        bus.i_res_rdy = 1'b0;
        bus.i_start   = 1'b0;
        wait_res(got);
        checks++; if (!got) begin errors++; $display("FAIL b2b_res_vld2: not seen within 200 cycles, want 1"); end
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++; if (bus.o_idx !== e.idx || bus.o_idx !== 2'd3) begin errors++; $display("FAIL b2b_idx2: got %0d want 3", bus.o_idx); end
        checks++; if (bus.o_max !== e.mx || bus.o_max !== 16'd4) begin errors++; $display("FAIL b2b_max2: got %0d want 4", bus.o_max); end
        checks++; if (pop_cnt != 4) begin errors++; $display("FAIL b2b_pops2: got %0d want 4", pop_cnt); end
        ack();
    endtask

    task automatic test_mid_reset();
        bit got;
        bit seen;
        exp_t e = 'x;
        start_pass(16'd5, 16'd9, 16'd3, 16'd7);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (vld_cnt >= 2) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_mid_vld: got %0d scores want 2", vld_cnt); end
        // The aborted pass never reports, so its expectation is dropped along with the FIFO.
        if (exp_q.size() > 0) exp_q.delete(0);
        flush_req = 1'b1;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #2;
        checks++; if (bus.o_pop !== 1'b0) begin errors++; $display("FAIL rst_mid_pop: got %b want 0", bus.o_pop); end
        checks++; if (bus.o_res_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_res_vld: got %b want 0", bus.o_res_vld); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.o_busy); end
        checks++; if (bus.o_idx !== '0) begin errors++; $display("FAIL rst_mid_idx: got %0d want 0", bus.o_idx); end
        checks++; if (bus.o_max !== '0) begin errors++; $display("FAIL rst_mid_max: got %0d want 0", bus.o_max); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #2;
        start_pass(16'd1, 16'd2, 16'd3, 16'd4);
        wait_res(got);
        checks++; if (!got) begin errors++; $display("FAIL rst_new_res_vld: not seen within 200 cycles, want 1"); end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++; if (bus.o_idx !== e.idx || bus.o_idx !== 2'd3) begin errors++; $display("FAIL rst_new_idx: got %0d want 3", bus.o_idx); end
        checks++; if (bus.o_max !== e.mx || bus.o_max !== 16'd4) begin errors++; $display("FAIL rst_new_max: got %0d want 4", bus.o_max); end
        ack();
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_start   = 1'b0;
        bus.i_res_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        test_reset();
        test_basic();
        test_ties();
        test_signedness();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
